// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package riscv_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned WORD_BYTES  = 4;
   localparam int unsigned LANE_CNT_W  = $clog2(WORD_BYTES);
   localparam int unsigned LANE_LSB_W  = $clog2(XLEN);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } loader_state_t;

   // Bit offset of a byte lane inside a little-endian word
   function automatic logic [LANE_LSB_W-1:0] lane_lsb(input logic [LANE_CNT_W-1:0] lane);
      return LANE_LSB_W'(lane) << 3;
   endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects accepted bytes into little-endian lanes of a 32-bit word.
module loader_word_assembler
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_accept,
   input  logic [BYTE_W-1:0] i_byte,
   input  logic              i_clear,
   output logic [XLEN-1:0]   o_word_c,
   output logic              o_word_full_c
);

   logic [LANE_CNT_W-1:0] r_byte_cnt;
   logic [XLEN-1:0]       r_word;
   logic [XLEN-1:0]       w_word;

   // Word as it will look once the byte offered this cycle lands in its lane
   always_comb begin
      w_word = r_word;
      if (i_accept) begin
         w_word[lane_lsb(r_byte_cnt) +: BYTE_W] = i_byte;
      end
   end

   // Lane storage and byte counter; cleared once the word has been written out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (i_clear) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (i_accept) begin
         r_byte_cnt <= r_byte_cnt + LANE_CNT_W'(1);
         r_word     <= w_word;
      end
   end

   assign o_word_c      = w_word;
   // The next accepted byte fills the top lane
   assign o_word_full_c = (r_byte_cnt == LANE_CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the CPU in reset until done.
module imem_loader
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DEPTH_WORDS = 256
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [BYTE_W-1:0]     in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [XLEN-1:0]       mem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_WORDS - 1);

   loader_state_t         r_state;
   logic [ADDR_WIDTH-1:0] r_word_cnt;
   logic                  r_last_pending;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [XLEN-1:0]       r_mem_wdata;
   logic                  r_cpu_reset;
   logic                  r_done;
   logic                  r_error;

   logic                  w_accept;
   logic                  w_clear;
   logic [XLEN-1:0]       w_word;
   logic                  w_word_full;

   // Only LOAD takes bytes; reset blocks acceptance immediately
   assign in_ready = (r_state == LOAD) && !reset;
   assign w_accept = in_valid && in_ready;
   assign w_clear  = (r_state == WRITE);

   loader_word_assembler u_asm (
      .clk           (clk),
      .reset         (reset),
      .i_accept      (w_accept),
      .i_byte        (in_data),
      .i_clear       (w_clear),
      .o_word_c      (w_word),
      .o_word_full_c (w_word_full)
   );

   // Loader FSM with registered memory-write and status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= LOAD;
         r_word_cnt     <= '0;
         r_last_pending <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_cpu_reset    <= 1'b1;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            LOAD: begin
               if (w_accept) begin
                  if (w_word_full) begin
                     // Word complete: present it to memory on the next cycle
                     r_state        <= WRITE;
                     r_last_pending <= in_last;
                     r_mem_we       <= 1'b1;
                     r_mem_addr     <= r_word_cnt;
                     r_mem_wdata    <= w_word;
                  end else if (in_last) begin
                     // Image ended mid-word; the partial word is dropped
                     r_state <= ERR;
                     r_error <= 1'b1;
                  end
               end
            end
            WRITE: begin
               r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
               if (r_last_pending) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_cpu_reset <= 1'b0;
               end else if (r_word_cnt == LAST_ADDR) begin
                  // Memory is full and the image keeps going
                  r_state <= ERR;
                  r_error <= 1'b1;
               end else begin
                  r_state <= LOAD;
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            ERR: begin
               r_state <= ERR;
            end
            default: begin
               r_state <= ERR;
               r_error <= 1'b1;
            end
         endcase
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_reset = r_cpu_reset;
   assign done      = r_done;
   assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a small-depth memory to reach overflow.
module tb_imem_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk      = 1'b0;
   logic              reset    = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data  = 8'h00;
   logic              in_last  = 1'b0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_reset;
   logic              done;
   logic              error;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] img[$];
   bit         exp_done;
   bit         exp_err;
   int         n_send;
   int         n_checks = 0;
   int         n_fail   = 0;

   imem_loader #(.ADDR_WIDTH(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: outcome of an image follows from its length and the memory depth
   task automatic model_image();
      int  nb;
      int  nwr;
      wr_t e;
      nb = img.size();
      if (nb > 4 * DEPTH) begin
         nwr = DEPTH; exp_done = 1'b0; exp_err = 1'b1; n_send = 4 * DEPTH;
      end else if ((nb % 4) != 0) begin
         nwr = nb / 4; exp_done = 1'b0; exp_err = 1'b1; n_send = nb;
      end else begin
         nwr = nb / 4; exp_done = 1'b1; exp_err = 1'b0; n_send = nb;
      end
      for (int k = 0; k < nwr; k++) begin
         e.addr = 8'(k);
         e.data = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
         exp_q.push_back(e);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(e.addr));
               check("wr_data", mem_wdata, e.data);
            end
         end
      end
   end

   // Called in the low clock phase; asserts reset between edges
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_error",     32'(error),     32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_wdata", mem_wdata,      32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rel_in_ready",  32'(in_ready),  32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit last, input int stall);
      int w;
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
      end
      w = 0;
      while (!in_ready) begin
         if (w == 16) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1 within 16 cycles");
            in_valid = 1'b0;
            return;
         end
         w++;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic poke_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      in_last  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_term();
      int w;
      w = 0;
      while (!(done || error) && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("term_reached", 32'(done | error), 32'd1);
      check("term_done",    32'(done),      32'(exp_done));
      check("term_error",   32'(error),     32'(exp_err));
      check("term_cpu_rst", 32'(cpu_reset), 32'(!exp_done));
      check("term_ready",   32'(in_ready),  32'd0);
   endtask

   task automatic run_image(input bit rnd_stall, input int stall_idx, input int stall_len);
      int st;
      model_image();
      for (int i = 0; i < n_send; i++) begin
         if (i == stall_idx) st = stall_len;
         else if (rnd_stall && ($urandom % 4 == 0)) st = int'($urandom_range(1, 3));
         else st = 0;
         send_byte(img[i], (i == img.size() - 1), st);
         if ((i % 4) == 3) check("we_latency", 32'(mem_we), 32'd1);
      end
      wait_term();
      for (int i = n_send; i < img.size(); i++) poke_byte(img[i]);
      poke_byte(8'($urandom));
      poke_byte(8'($urandom));
      repeat (2) @(negedge clk);
      check("writes_pending", 32'(exp_q.size()), 32'd0);
      check("sticky_done",    32'(done),  32'(exp_done));
      check("sticky_error",   32'(error), 32'(exp_err));
   endtask

   task automatic load_test1_img();
      img.delete();
      img.push_back(8'h13); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
      img.push_back(8'h93); img.push_back(8'h00); img.push_back(8'h10); img.push_back(8'h00);
   endtask

   initial begin
      wr_t e;
      int  idx;
      int  nb;

      // 1: two-word image
      do_reset();
      load_test1_img();
      run_image(1'b0, -1, 0);

      // 2: three idle cycles between bytes 2 and 3
      do_reset();
      load_test1_img();
      run_image(1'b0, 2, 3);

      // 3: six-byte image ends mid-word
      do_reset();
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back(8'(8'h40 + i));
      run_image(1'b0, -1, 0);

      // 4: twenty bytes overflow a four-word memory
      do_reset();
      img.delete();
      for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
      run_image(1'b0, -1, 0);

      // 5: reset mid-load, then reload a single word
      do_reset();
      load_test1_img();
      e.addr = 8'h00;
      e.data = 32'h0000_0013;
      exp_q.push_back(e);
      for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0, 0);
      do_reset();
      img.delete();
      img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC); img.push_back(8'hDD);
      run_image(1'b0, -1, 0);

      // 6: back-to-back stream, check ready pattern and completion cycle
      do_reset();
      load_test1_img();
      model_image();
      idx = 0;
      for (int k = 1; k <= 11; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= 10) check($sformatf("b2b_ready_c%0d", k), 32'(in_ready), 32'(!(k == 5 || k == 10)));
         if (in_ready && idx < 8) begin
            in_valid = 1'b1;
            in_data  = img[idx];
            in_last  = (idx == 7);
            idx++;
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
      end
      check("b2b_done_c11",    32'(done),      32'd1);
      check("b2b_cpu_rst_c11", 32'(cpu_reset), 32'd0);
      check("b2b_bytes_sent",  32'(idx),       32'd8);
      @(negedge clk);
      check("b2b_writes",      32'(exp_q.size()), 32'd0);

      // Randomized images: well-formed, truncated and oversize, with random stalls
      for (int it = 0; it < 12; it++) begin
         do_reset();
         img.delete();
         nb = 4 * int'($urandom_range(1, DEPTH + 2));
         if ($urandom % 3 == 0) nb = nb - int'($urandom_range(1, 3));
         for (int i = 0; i < nb; i++) img.push_back(8'($urandom));
         run_image(1'b1, -1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader that sits directly upstream of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses starting at 0.
- Holds the CPU in reset until the final word is written, replacing file-based preload on the FPGA build.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory.
- DEPTH_WORDS, 256, instruction memory capacity in words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_last  in  1  marks the final byte of the image; qualified by in_valid.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  word address of the write.
- mem_wdata  out  32  assembled word.
- cpu_reset  out  1  reset to CPU core; high until load completes.
- done  out  1  load completed successfully; sticky.
- error  out  1  malformed or oversize image; sticky.

Behaviour:
- Reset (async assert, sync release):
  - State = LOAD; byte_cnt = 0; word_cnt = 0; word shift register = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_reset = 1, done = 0, error = 0.
  - in_ready = 0 while reset is high.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is combinational: 1 in LOAD only.
- State LOAD:
  - Each accepted byte goes into byte lane byte_cnt (byte 0 → bits 7:0, byte 3 → bits 31:24); byte_cnt increments.
  - in_last accepted with byte_cnt != 3 → ERR. The partial word is discarded and never written.
  - Accepting byte 3 → WRITE; the registered flag last_pending is set to the value of in_last.
- State WRITE (exactly one cycle; in_ready = 0):
  - mem_we = 1, mem_addr = word_cnt, mem_wdata = assembled word.
  - Next edge: word_cnt++, byte_cnt = 0.
  - Transition:
    - last_pending → DONE.
    - else if word_cnt == DEPTH_WORDS-1 → ERR (image overflows memory).
    - else → LOAD.
- State DONE (terminal until reset):
  - done = 1, cpu_reset = 0, in_ready = 0, mem_we = 0.
  - mem_addr and mem_wdata hold their last values.
- State ERR (terminal until reset):
  - error = 1, cpu_reset = 1, in_ready = 0, mem_we = 0.
- Latency and throughput:
  - mem_we asserts in the cycle after the 4th byte is accepted.
  - cpu_reset deasserts in the cycle after the final WRITE cycle.
  - Maximum throughput is 4 bytes per 5 cycles.
- Outputs mem_we, mem_addr, mem_wdata, cpu_reset, done and error are registered.
- Stalls: in_valid low for any number of cycles preserves byte_cnt and the partial word.
- in_data and in_last are ignored when in_valid = 0 or in_ready = 0.
- Reset mid-load: the partial word is lost, already-written words are not cleared, and cpu_reset reasserts immediately (asynchronously).
- A zero-byte image is impossible; the loader waits in LOAD indefinitely with cpu_reset = 1.

Decomposition:
- Shared package riscv_pkg adds:
  - loader_state_t enum {LOAD, WRITE, DONE, ERR}.
  - Constant WORD_BYTES = 4.
  - XLEN = 32, if not already present.
- Sub-module loader_word_assembler holds the byte lane shift register and byte_cnt. It outputs word and word_full; the FSM remains in imem_loader.

Test Plan:
1. Reset, then send bytes 13 00 00 00 93 00 10 00 with in_last on the 8th byte → writes addr 0 = 0x00000013 and addr 1 = 0x00100093. done = 1 and cpu_reset = 0 one cycle after the second write.
2. Same image with in_valid dropped for 3 cycles between bytes 2 and 3 → identical writes, no lost or duplicated byte, mem_we still pulses exactly twice.
3. Send 6 bytes with in_last on the 6th → one write (addr 0) only, then error = 1, cpu_reset = 1, in_ready = 0. Further bytes are ignored.
4. DEPTH_WORDS = 4: stream 20 bytes, last on byte 20 → 4 writes (addr 0..3), then error = 1 after the 4th write. The 5th word is never written.
5. Assert reset asynchronously mid-cycle after byte 2 of word 1 → cpu_reset = 1 and mem_we = 0 immediately. Reloading 4 bytes AA BB CC DD with last → addr 0 = 0xDDCCBBAA, done = 1.
6. Back-to-back in_valid = 1 for 8 bytes → in_ready low exactly in cycles 5 and 10 after the first acceptance (the WRITE cycles). The total load completes in 10 cycles.
